// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a synchronous
// single-port RAM that has a 1-cycle read latency.
//
// Handshake: a requester raises Req with We/Addr/WData and holds all four
// stable until the cycle in which its Gnt is high. The RAM access is issued
// in that Gnt cycle. Req may drop or change at the clock edge that ends the
// Gnt cycle. A granted read returns RValid one cycle after Gnt, with RData on
// the shared RData bus. Dropping Req before Gnt abandons the request.
//
// Optional feature: define MEM_ARB_STATS_EN to add the saturating 16-bit
// per-requester grant counters Gnt_Cnt0/Gnt_Cnt1.
//
// Prio is brought out as a debug output so the round-robin state is visible.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              RValid0,
    output logic              RValid1,
    output logic [DATA_W-1:0] RData,
    output logic              Ram_En,
    output logic              Ram_We,
    output logic [ADDR_W-1:0] Ram_Addr,
    output logic [DATA_W-1:0] Ram_WData,
    input  logic [DATA_W-1:0] Ram_RData,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0]       Gnt_Cnt0,
    output logic [15:0]       Gnt_Cnt1,
`endif
    output logic              Prio
);

    // Requests that are eligible this cycle: the requester currently holding
    // the grant is masked so it is never granted two cycles in a row.
    logic elig0;
    logic elig1;
    logic gnt_nxt0;
    logic gnt_nxt1;

    assign elig0 = Req0 & ~Gnt0;
    assign elig1 = Req1 & ~Gnt1;

    // Next-grant selection: single eligible request wins, ties go to Prio.
    always_comb begin
        gnt_nxt0 = 1'b0;
        gnt_nxt1 = 1'b0;
        if (elig0 && elig1) begin
            if (Prio) begin
                gnt_nxt1 = 1'b1;
            end else begin
                gnt_nxt0 = 1'b1;
            end
        end else begin
            gnt_nxt0 = elig0;
            gnt_nxt1 = elig1;
        end
    end

    // Grant register and round-robin pointer; Prio flips to the other
    // requester whenever a grant is issued.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Gnt0 <= 1'b0;
            Gnt1 <= 1'b0;
            Prio <= 1'b0;
        end else begin
            Gnt0 <= gnt_nxt0;
            Gnt1 <= gnt_nxt1;
            if (gnt_nxt0) begin
                Prio <= 1'b1;
            end else if (gnt_nxt1) begin
                Prio <= 1'b0;
            end
        end
    end

    // RAM port driven straight from the granted requester's inputs; held
    // idle during reset even if a grant was registered in that cycle.
    always_comb begin
        Ram_En    = 1'b0;
        Ram_We    = 1'b0;
        Ram_Addr  = '0;
        Ram_WData = '0;
        if (!Rst) begin
            if (Gnt0) begin
                Ram_En    = 1'b1;
                Ram_We    = We0;
                Ram_Addr  = Addr0;
                Ram_WData = WData0;
            end else if (Gnt1) begin
                Ram_En    = 1'b1;
                Ram_We    = We1;
                Ram_Addr  = Addr1;
                Ram_WData = WData1;
            end
        end
    end

    // Read-valid tracking: a granted read returns data one cycle later; a
    // reset at the Gnt edge cancels the pending return.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            RValid0 <= 1'b0;
            RValid1 <= 1'b0;
        end else begin
            RValid0 <= Gnt0 & ~We0;
            RValid1 <= Gnt1 & ~We1;
        end
    end

    // Shared read-data bus: RAM output while a read returns, zero otherwise.
    always_comb begin
        RData = '0;
        if (RValid0 || RValid1) begin
            RData = Ram_RData;
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Saturating per-requester grant counters.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Gnt_Cnt0 <= 16'h0000;
            Gnt_Cnt1 <= 16'h0000;
        end else begin
            if (Gnt0 && (Gnt_Cnt0 != 16'hFFFF)) begin
                Gnt_Cnt0 <= Gnt_Cnt0 + 16'h0001;
            end
            if (Gnt1 && (Gnt_Cnt1 != 16'hFFFF)) begin
                Gnt_Cnt1 <= Gnt_Cnt1 + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// two-requester traffic, all checked against a transaction-level model
// (grant choice from eligibility + round-robin pointer, shadow memory for
// expected read data). Includes a behavioural synchronous RAM.
module tb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          prio;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1;
`endif

    // Clock
    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(clk), .Rst(rst),
        .Req0(req0), .Req1(req1), .We0(we0), .We1(we1),
        .Addr0(addr0), .Addr1(addr1), .WData0(wdata0), .WData1(wdata1),
        .Gnt0(gnt0), .Gnt1(gnt1), .RValid0(rvalid0), .RValid1(rvalid1),
        .RData(rdata), .Ram_En(ram_en), .Ram_We(ram_we), .Ram_Addr(ram_addr),
        .Ram_WData(ram_wdata), .Ram_RData(ram_rdata),
`ifdef MEM_ARB_STATS_EN
        .Gnt_Cnt0(gnt_cnt0), .Gnt_Cnt1(gnt_cnt1),
`endif
        .Prio(prio)
    );

    // Behavioural synchronous single-port RAM, 1-cycle read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    // Reference model state
    logic          m_g0, m_g1, m_prio;
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            m_cnt0, m_cnt1;
    int            checks = 0;
    int            errors = 0;
    bit            done0, done1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    // One clock cycle: check the combinational RAM port for the current
    // cycle, predict the next cycle from the model, then check the DUT.
    task automatic tick();
        logic          n_g0, n_g1, n_prio, e0, e1, n_rv0, n_rv1;
        logic [DW-1:0] n_rdata;
        #1;
        if (!rst && m_g0) begin
            chk("ram_en", ram_en, 1); chk("ram_we", ram_we, we0);
            chk("ram_addr", ram_addr, addr0); chk("ram_wdata", ram_wdata, wdata0);
        end else if (!rst && m_g1) begin
            chk("ram_en", ram_en, 1); chk("ram_we", ram_we, we1);
            chk("ram_addr", ram_addr, addr1); chk("ram_wdata", ram_wdata, wdata1);
        end else begin
            chk("ram_en_idle", ram_en, 0); chk("ram_we_idle", ram_we, 0);
            chk("ram_addr_idle", ram_addr, 0); chk("ram_wdata_idle", ram_wdata, 0);
        end
        n_g0 = 0; n_g1 = 0; n_prio = m_prio; n_rv0 = 0; n_rv1 = 0; n_rdata = '0;
        if (rst) begin
            n_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            e0 = req0 && !m_g0;
            e1 = req1 && !m_g1;
            if (e0 && e1) begin
                if (m_prio) n_g1 = 1; else n_g0 = 1;
            end else begin
                n_g0 = e0; n_g1 = e1;
            end
            if (n_g0) n_prio = 1; else if (n_g1) n_prio = 0;
            if (m_g0 && !we0) begin n_rv0 = 1; n_rdata = shadow[addr0]; end
            if (m_g1 && !we1) begin n_rv1 = 1; n_rdata = shadow[addr1]; end
            if (m_g0 && we0) shadow[addr0] = wdata0;
            if (m_g1 && we1) shadow[addr1] = wdata1;
            if (m_g0 && m_cnt0 < 65535) m_cnt0++;
            if (m_g1 && m_cnt1 < 65535) m_cnt1++;
        end
        @(posedge clk);
        #1;
        m_g0 = n_g0; m_g1 = n_g1; m_prio = n_prio;
        chk("gnt0", gnt0, n_g0);
        chk("gnt1", gnt1, n_g1);
        chk("rvalid0", rvalid0, n_rv0);
        chk("rvalid1", rvalid1, n_rv1);
        chk("rdata", rdata, n_rdata);
        chk("prio", prio, n_prio);
`ifdef MEM_ARB_STATS_EN
        chk("gnt_cnt0", gnt_cnt0, m_cnt0);
        chk("gnt_cnt1", gnt_cnt1, m_cnt1);
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst = 1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        m_g0 = 0; m_g1 = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);

        // Reset
        do_reset(2);
        chk("reset_gnt0", gnt0, 0);
        chk("reset_prio", prio, 0);

        // Write F0F0F0F0 to address 5, then read it back
        set0(1, 1, 6'd5, 32'hF0F0_F0F0);
        tick();
        chk("wr_gnt0", gnt0, 1);
        tick();
        set0(1, 0, 6'd5, 32'h0);
        tick();
        chk("rd_gnt0", gnt0, 1);
        tick();
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata_f0", rdata, 32'hF0F0_F0F0);
        req0 = 0;
        tick();

        // Simultaneous requests after reset: requester 0 first, then 1
        do_reset(1);
        set0(1, 0, 6'd5, '0);
        set1(1, 0, 6'd6, '0);
        tick();
        chk("both_first_gnt0", gnt0, 1);
        req0 = 0;
        tick();
        chk("both_second_gnt1", gnt1, 1);
        req1 = 0;
        tick();
        chk("both_prio_end", prio, 0);
        tick();

        // Both requesters holding reads: strict alternation
        set0(1, 0, 6'd5, '0);
        set1(1, 0, 6'd9, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("alt_gnt0", gnt0, (i % 2) == 0);
            chk("alt_gnt1", gnt1, (i % 2) == 1);
        end
        req0 = 0; req1 = 0;
        tick();
        tick();

        // Requester 1 alone: granted every other cycle
        set1(1, 0, 6'd5, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("solo_gnt1", gnt1, (i % 2) == 0);
        end
        req1 = 0;
        tick();
        tick();

        // Reset in a read's Gnt cycle cancels the read
        set0(1, 0, 6'd7, '0);
        tick();
        chk("rst_rd_gnt0", gnt0, 1);
        rst = 1;
        req0 = 0;
        tick();
        rst = 0;
        tick();
        chk("rst_rd_rvalid0", rvalid0, 0);
        chk("rst_rd_gnt", gnt0 | gnt1, 0);
        chk("rst_rd_prio", prio, 0);

        // Random traffic, small address range to hit write-then-read pairs
        done0 = 0; done1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (m_g0) done0 = 1;
            else if (!req0 || done0) begin
                done0 = 0;
                if ($urandom_range(0, 2) != 0)
                    set0(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
                else
                    req0 = 0;
            end
            if (m_g1) done1 = 1;
            else if (!req1 || done1) begin
                done1 = 0;
                if ($urandom_range(0, 2) != 0)
                    set1(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
                else
                    req1 = 0;
            end
            tick();
        end
        req0 = 0; req1 = 0;
        tick();
        tick();

`ifdef MEM_ARB_STATS_EN
        // Counters: 3 grants to requester 0, 2 to requester 1
        do_reset(1);
        set0(1, 0, 6'd1, '0);
        set1(1, 0, 6'd2, '0);
        for (int i = 0; i < 5; i++) tick();
        req0 = 0; req1 = 0;
        tick();
        tick();
        chk("stats_cnt0", gnt_cnt0, 16'd3);
        chk("stats_cnt1", gnt_cnt1, 16'd2);

        // Saturation at FFFF
        dut.Gnt_Cnt0 = 16'hFFFF;
        m_cnt0 = 65535;
        set0(1, 0, 6'd1, '0);
        for (int i = 0; i < 4; i++) tick();
        req0 = 0;
        tick();
        tick();
        chk("stats_sat", gnt_cnt0, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
